// File: rtl/pipe_list_pkg.sv
// Shared types and screen constants for the pipe game datapath.
package pipe_list_pkg;

    // Visible play-field size in pixels.
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // Default number of pipes the game keeps on screen at once.
    localparam int PIPE_CAPACITY = 16;

    // x is signed so a pipe can keep scrolling past the left edge
    // before it is retired.
    typedef struct packed {
        logic signed [11:0] x;
        logic        [10:0] y;
    } pipe_t;

    // Convenience constructor for a pipe record.
    function automatic pipe_t make_pipe(input logic signed [11:0] x,
                                        input logic        [10:0] y);
        pipe_t p;
        p.x = x;
        p.y = y;
        return p;
    endfunction

endpackage

// File: rtl/pipe_list.sv
// Ordered, fixed-capacity list of pipe records. New pipes are appended at
// the tail; one iteration pass walks the list oldest-first, letting the
// caller rewrite each element in place or drop it. Dropped elements are
// compacted out during the same pass by a separate write pointer.
module pipe_list
    import pipe_list_pkg::*;
#(
    parameter int CAPACITY = PIPE_CAPACITY,
    parameter int COUNT_W  = $clog2(CAPACITY + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    output logic [COUNT_W-1:0] count,
    input  logic               insert_en,
    input  pipe_t              insert_data,
    input  logic               iter_start,
    input  pipe_t              iter_in,
    output pipe_t              iter_out,
    output logic               iter_out_valid,
    input  logic               iter_remove
);

    localparam int IDX_W = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;

    pipe_t              mem_reg [CAPACITY];
    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] rd_reg;
    logic [COUNT_W-1:0] wr_reg;
    logic               active_reg;

    logic               insert_accept;
    logic               step;
    logic               keep;
    logic               last_step;
    logic [COUNT_W-1:0] wr_next;
    logic [COUNT_W-1:0] last_pos;
    logic [IDX_W-1:0]   rd_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   tail_idx;
    logic [IDX_W-1:0]   last_idx;

    // Decode of the current cycle's actions. Insert and step are mutually
    // exclusive because insert is only accepted while no pass is active.
    always_comb begin
        insert_accept = insert_en && !active_reg && (count_reg < COUNT_W'(CAPACITY));
        step          = active_reg && (rd_reg < count_reg);
        keep          = step && !iter_remove;
        wr_next       = keep ? (wr_reg + COUNT_W'(1)) : wr_reg;
        last_step     = step && ((rd_reg + COUNT_W'(1)) == count_reg);
        last_pos      = count_reg - COUNT_W'(1);
        rd_idx        = rd_reg[IDX_W-1:0];
        wr_idx        = wr_reg[IDX_W-1:0];
        tail_idx      = count_reg[IDX_W-1:0];
        last_idx      = last_pos[IDX_W-1:0];
    end

    // Output view: the live element during a pass, otherwise the newest pipe.
    always_comb begin
        iter_out_valid = step;
        count          = count_reg;
        if (step) begin
            iter_out = mem_reg[rd_idx];
        end else if (count_reg != '0) begin
            iter_out = mem_reg[last_idx];
        end else begin
            iter_out = '0;
        end
    end

    // Record storage: tail append on insert, compacting write-back during a pass.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CAPACITY; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (ce) begin
            if (insert_accept) begin
                mem_reg[tail_idx] <= insert_data;
            end else if (keep) begin
                mem_reg[wr_idx] <= iter_in;
            end
        end
    end

    // Pass sequencing and occupancy count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg  <= '0;
            rd_reg     <= '0;
            wr_reg     <= '0;
            active_reg <= 1'b0;
        end else if (ce) begin
            if (insert_accept) begin
                count_reg <= count_reg + COUNT_W'(1);
            end
            if (!active_reg) begin
                // A start in the same cycle as an accepted insert still
                // covers the new entry, since the pass reads count next cycle.
                if (iter_start) begin
                    active_reg <= 1'b1;
                    rd_reg     <= '0;
                    wr_reg     <= '0;
                end
            end else if (step) begin
                rd_reg <= rd_reg + COUNT_W'(1);
                wr_reg <= wr_next;
                if (last_step) begin
                    count_reg  <= wr_next;
                    active_reg <= 1'b0;
                end
            end else begin
                // Pass over an empty list: nothing to present, just finish.
                active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_list.sv
// Self-checking bench for pipe_list: table-driven inserts, scoreboarded
// iteration passes, clock-enable stalls, overflow and asynchronous reset.
module tb_pipe_list;
    import pipe_list_pkg::*;

    localparam int CAP = 16;
    localparam int CW  = $clog2(CAP + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b1;
    logic [CW-1:0] count;
    logic          insert_en = 1'b0;
    pipe_t         insert_data = '0;
    logic          iter_start = 1'b0;
    pipe_t         iter_in = '0;
    pipe_t         iter_out;
    logic          iter_out_valid;
    logic          iter_remove = 1'b0;

    int n_total = 0;
    int n_pass  = 0;

    pipe_t model[$];

    pipe_list #(.CAPACITY(CAP), .COUNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .ce             (ce),
        .count          (count),
        .insert_en      (insert_en),
        .insert_data    (insert_data),
        .iter_start     (iter_start),
        .iter_in        (iter_in),
        .iter_out       (iter_out),
        .iter_out_valid (iter_out_valid),
        .iter_remove    (iter_remove)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic pipe_t model_last();
        if (model.size() == 0) return '0;
        return model[model.size() - 1];
    endfunction

    // One insert: drive at negedge, check at the following negedge.
    task automatic do_insert(input pipe_t d, input int exp_count, input pipe_t exp_last);
        @(negedge clk);
        insert_en   = 1'b1;
        insert_data = d;
        if (model.size() < CAP) model.push_back(d);
        @(negedge clk);
        insert_en = 1'b0;
        $display("insert x=%0d y=%0d -> count=%0d", d.x, d.y, count);
        chk("ins_count", 32'(count), 32'(exp_count));
        chk("ins_valid", 32'(iter_out_valid), 32'd0);
        chk("ins_last", 32'(iter_out), 32'(exp_last));
    endtask

    // One full pass. Expected elements are queued at start and popped as
    // the DUT presents them; the model is rebuilt from the kept write-backs.
    task automatic run_pass(input logic [31:0] rm_mask, input bit xdec, input int stall_at,
                            input bit ins_during, input bit preinsert, input pipe_t pre_data);
        pipe_t exp_q[$];
        pipe_t new_model[$];
        pipe_t e;
        pipe_t wb;
        int    n_exp;
        int    idx;
        @(negedge clk);
        iter_start = 1'b1;
        if (preinsert) begin
            insert_en   = 1'b1;
            insert_data = pre_data;
            if (model.size() < CAP) model.push_back(pre_data);
        end
        exp_q = model;
        n_exp = exp_q.size();
        @(negedge clk);
        iter_start  = 1'b0;
        insert_en   = ins_during;
        insert_data = make_pipe(12'sd7, 11'd7);
        idx = 0;
        for (int cyc = 0; cyc < CAP + 4; cyc++) begin
            if (!iter_out_valid) break;
            if (exp_q.size() == 0) begin
                chk("pass_extra_elem", 32'(idx), 32'(n_exp));
                break;
            end
            e = exp_q.pop_front();
            $display("pass elem %0d x=%0d y=%0d", idx, iter_out.x, iter_out.y);
            chk("pass_elem", 32'(iter_out), 32'(e));
            chk("pass_count_held", 32'(count), 32'(n_exp));
            if (idx == stall_at) begin
                ce = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(iter_out_valid), 32'd1);
                    chk("stall_elem", 32'(iter_out), 32'(e));
                end
                ce = 1'b1;
            end
            iter_remove = rm_mask[idx];
            wb = e;
            if (xdec) wb.x = e.x - 12'sd1;
            iter_in = wb;
            if (!rm_mask[idx]) new_model.push_back(wb);
            idx++;
            @(negedge clk);
        end
        insert_en   = 1'b0;
        iter_remove = 1'b0;
        model = new_model;
        $display("pass end: presented=%0d count=%0d", idx, count);
        chk("pass_len", 32'(idx), 32'(n_exp));
        chk("pass_end_valid", 32'(iter_out_valid), 32'd0);
        chk("pass_end_count", 32'(count), 32'(model.size()));
        chk("pass_end_last", 32'(iter_out), 32'(model_last()));
    endtask

    typedef struct {
        pipe_t data;
        int    exp_count;
        pipe_t exp_last;
    } ins_vec_t;

    ins_vec_t ins_tab[3];

    initial begin
        ins_tab[0] = '{make_pipe(12'sd639, 11'd50),  1, make_pipe(12'sd639, 11'd50)};
        ins_tab[1] = '{make_pipe(12'sd500, 11'd80),  2, make_pipe(12'sd500, 11'd80)};
        ins_tab[2] = '{make_pipe(12'sd300, 11'd120), 3, make_pipe(12'sd300, 11'd120)};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(iter_out_valid), 32'd0);
        chk("rst_out", 32'(iter_out), 32'd0);
        rst = 1'b1;

        // Pass over an empty list presents nothing.
        run_pass(32'd0, 1'b0, -1, 1'b0, 1'b0, '0);

        // Table-driven inserts.
        for (int i = 0; i < 3; i++)
            do_insert(ins_tab[i].data, ins_tab[i].exp_count, ins_tab[i].exp_last);

        // Move every pipe left by one.
        run_pass(32'd0, 1'b1, -1, 1'b0, 1'b0, '0);
        // Remove the first; next pass shows the survivors unchanged in order.
        run_pass(32'd1, 1'b0, -1, 1'b0, 1'b0, '0);
        // Stall mid-pass with ce=0 and try to insert during the pass.
        run_pass(32'd0, 1'b0, 1, 1'b1, 1'b0, '0);
        // Insert and start in the same cycle: the pass includes the new entry.
        run_pass(32'd0, 1'b0, -1, 1'b0, 1'b1, make_pipe(-12'sd20, 11'd200));

        // Fill to capacity, then overflow.
        while (model.size() < CAP) begin
            pipe_t d;
            d = make_pipe(12'(model.size() * 10), 11'(model.size() + 300));
            do_insert(d, model.size() + 1, d);
        end
        do_insert(make_pipe(12'sd1, 11'd1), CAP, model_last());

        // Full-list compaction: drop every odd element, decrement the rest.
        run_pass(32'hAAAA, 1'b1, -1, 1'b0, 1'b0, '0);
        run_pass(32'd0, 1'b0, -1, 1'b0, 1'b0, '0);

        // Asynchronous reset mid-pass.
        @(negedge clk);
        iter_start = 1'b1;
        @(negedge clk);
        iter_start = 1'b0;
        chk("pre_rst_valid", 32'(iter_out_valid), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        $display("async reset: valid=%0d count=%0d", iter_out_valid, count);
        chk("arst_valid", 32'(iter_out_valid), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out", 32'(iter_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        model.delete();
        @(negedge clk);
        iter_start = 1'b1;
        @(negedge clk);
        iter_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_valid", 32'(iter_out_valid), 32'd0);
            @(negedge clk);
        end
        chk("post_rst_count", 32'(count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
